demux_stream_sched: RTL and testbench
=====================================

DEMUX_STREAM_SCHED -- requirements
Module: demux_stream_sched

Interface
REQ-001 Parameter DW, default 8: data width in bits.
REQ-002 Parameter N, default 4: number of output channels; power of two, 2..8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_data  input  DW  upstream payload.
REQ-007 in_sel  input  log2(N)  destination index, used in addressed mode.
REQ-008 in_ready  output  1  block accepts the beat this cycle.
REQ-009 mode  input  1  0 = round-robin, 1 = addressed.
REQ-010 out_valid  output  N  one-hot; bit k = beat pending for channel k.
REQ-011 out_data  output  DW  payload shared by all channels.
REQ-012 out_ready  input  N  per-channel sink ready.
REQ-013 busy  output  1  holding register occupied.
REQ-014 out_cnt  output  N*16  per-channel delivered-beat counters, channel k at bits [16k+15:16k]; present only with DEMUX_CNT_EN.

Function
REQ-015 Accept = in_valid & in_ready; deliver(k) = out_valid[k] & out_ready[k].
REQ-016 Two-state FSM: IDLE (holding register empty) and HOLD (holding register full).
REQ-017 IDLE: in_ready=1, out_valid=0; accept -> capture in_data and dest, go to HOLD.
REQ-018 HOLD: out_valid = onehot(dest), out_data = held data, stable until delivered.
REQ-019 HOLD: in_ready = out_ready[dest]; deliver with simultaneous accept -> reload, stay in HOLD (1 beat/cycle sustained).
REQ-020 HOLD: deliver without accept -> IDLE next cycle.
REQ-021 Latency: beat accepted in cycle n appears on out_valid in cycle n+1.
REQ-022 Round-robin mode: dest = rr_ptr at accept; rr_ptr increments mod N on each accept, wrapping N-1 -> 0.
REQ-023 Addressed mode: dest = in_sel sampled at accept; rr_ptr unchanged.
REQ-024 mode is sampled only at accept; a change never redirects a beat already held.
REQ-025 Blocked destination stalls the stream (head-of-line); no beat skips, reorders or drops.
REQ-026 out_valid never asserts more than one bit; busy = (state==HOLD).
REQ-027 in_data/in_sel ignored when no accept.

Reset
REQ-028 rst forces IDLE, rr_ptr=0, out_valid=0, out_data=0, busy=0, in_ready=0 during rst cycle, out_cnt=0.
REQ-029 rst during HOLD discards the held beat; no delivery is counted for it.
REQ-030 in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro DEMUX_CNT_EN defined: out_cnt present; counter k increments by 1 on deliver(k), wraps 0xFFFF -> 0x0000.
REQ-032 DEMUX_CNT_EN undefined: out_cnt port and counters absent; all other behaviour identical.

Structure
REQ-033 Shared package demux_sched_pkg holds the FSM state enum (IDLE, HOLD), counter width constant 16 and mode encodings.
REQ-034 Round-robin pointer in sub-module demux_rr_ptr (inputs clk, rst, advance; output ptr); the existing 1:2 dataflow demux is not instantiated.

Verification
REQ-035 RR, all out_ready=1, 8 beats 0x10..0x17 back-to-back -> channels 0,1,2,3,0,1,2,3 in order, in_ready held 1, each beat one cycle after accept.
REQ-036 RR, out_ready[1]=0 for 5 cycles, beats 0xA0,0xA1,0xA2 -> 0xA1 held on out_valid[1] with stable data, in_ready=0, 0xA2 waits; release -> 0xA1 then 0xA2 on ch2.
REQ-037 Addressed, in_sel=3,3,0 with 0x55,0x66,0x77 -> ch3,ch3,ch0; rr_ptr unchanged afterwards (next RR beat goes to ch0).
REQ-038 Mode toggled from 0 to 1 while beat held for ch2 -> beat still delivered on ch2.
REQ-039 rst asserted while HOLD for ch1 -> next cycle out_valid=0, busy=0, cnt[1] unchanged, rr_ptr=0.
REQ-040 DEMUX_CNT_EN, 65537 deliveries to ch0 -> out_cnt[15:0]=0x0001, other channels 0; build without macro compiles and passes REQ-035.

Source files
------------

// File: rtl/demux_stream_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_sched_pkg: shared FSM states, counter width, mode encodings |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package demux_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int CNT_W = 16;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/demux_stream_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_stream_sched_if: upstream/downstream stream bundle          |
// | out_cnt exists only when DEMUX_CNT_EN is defined. Rev 1.0          |
// +------------------------------------------------------------------+
interface demux_stream_sched_if #(
  parameter int DW = 8,
  parameter int N  = 4
);
  import demux_sched_pkg::*;

  localparam int SW = $clog2(N);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_sel;
  logic          in_ready;
  logic          mode;
  logic [N-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_ready;
  logic          busy;
`ifdef DEMUX_CNT_EN
  logic [N*CNT_W-1:0] out_cnt;
`endif

`ifdef DEMUX_CNT_EN
  modport master (
    output in_valid, in_data, in_sel, mode, out_ready,
    input  in_ready, out_valid, out_data, busy, out_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, mode, out_ready,
    output in_ready, out_valid, out_data, busy, out_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_sel, mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_data, in_sel, mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );
`endif

endinterface
`default_nettype wire

// File: rtl/demux_stream_sched_rr_ptr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_rr_ptr: round-robin destination pointer, wraps N-1 -> 0     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module demux_rr_ptr #(
  parameter int N = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 advance,
  output logic [$clog2(N)-1:0]      ptr
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/demux_stream_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_stream_sched: 1:N stream demux, round-robin or addressed    |
// | Optional per-channel delivery counters under DEMUX_CNT_EN. Rev 1.0 |
// +------------------------------------------------------------------+
module demux_stream_sched
  import demux_sched_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input wire logic              clk,
  input wire logic              rst,
  demux_stream_sched_if.slave   bus
);

  localparam int SW = $clog2(N);

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] dest_q, dest_d;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] dest_in;
  logic          accept;
  logic          deliver;
  logic          rr_adv;
  logic          in_ready_w;
  logic [N-1:0]  out_valid_w;

  // A held beat only frees the register when its own sink takes it,
  // which keeps the stream in order behind a blocked channel.
  assign deliver    = (state_q == HOLD) && bus.out_ready[dest_q];
  assign in_ready_w = !rst && ((state_q == IDLE) || bus.out_ready[dest_q]);
  assign accept     = bus.in_valid && in_ready_w;
  assign dest_in    = (bus.mode == MODE_ADDR) ? bus.in_sel : rr_ptr;
  assign rr_adv     = accept && (bus.mode == MODE_RR);

  demux_rr_ptr #(
    .N (N)
  ) u_rr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (rr_adv),
    .ptr     (rr_ptr)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
          data_d  = bus.in_data;
          dest_d  = dest_in;
        end
      end
      HOLD: begin
        if (accept) begin
          data_d = bus.in_data;
          dest_d = dest_in;
        end else if (deliver) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    out_valid_w = '0;
    if (state_q == HOLD) begin
      out_valid_w[dest_q] = 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q == HOLD);

`ifdef DEMUX_CNT_EN
  for (genvar k = 0; k < N; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (deliver && (dest_q == SW'(k))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign bus.out_cnt[k*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_demux_stream_sched: directed self-checking bench, DW=8, N=4    |
// | Counter checks compile in only with DEMUX_CNT_EN. Rev 1.0          |
// +------------------------------------------------------------------+
module tb_demux_stream_sched;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  demux_stream_sched_if #(.DW(8), .N(4)) bus ();

  demux_stream_sched #(
    .DW (8),
    .N  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ov, input logic [7:0] od);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(ov));
    chk({tag, "_data"},  64'(bus.out_data),  64'(od));
  endtask

  initial begin
    logic [3:0] exp_ov;
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 4'hF;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk_out("rst_out", 4'b0000, 8'h00);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'h1);

    // Round-robin, all sinks ready, back-to-back beats
    bus.mode     = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_data = 8'(8'h10 + k);
      #1;
      chk("rr_in_ready", 64'(bus.in_ready), 64'h1);
      if (k > 0) begin
        exp_ov = 4'(1 << ((k - 1) % 4));
        chk_out("rr_beat", exp_ov, 8'(8'h10 + k - 1));
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk_out("rr_last", 4'b1000, 8'h17);
    tick();
    chk("rr_idle_valid", 64'(bus.out_valid), 64'h0);
    chk("rr_idle_busy", 64'(bus.busy), 64'h0);

    // Head-of-line blocking on channel 1
    bus.out_ready = 4'b1101;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA0;
    #1;
    chk("hol_a0_ready", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_data = 8'hA1;
    #1;
    chk_out("hol_a0", 4'b0001, 8'hA0);
    chk("hol_a1_ready", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_data = 8'hA2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_out("hol_stall", 4'b0010, 8'hA1);
      chk("hol_stall_ready", 64'(bus.in_ready), 64'h0);
      tick();
    end
    bus.out_ready = 4'hF;
    #1;
    chk("hol_release_ready", 64'(bus.in_ready), 64'h1);
    chk_out("hol_release", 4'b0010, 8'hA1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("hol_a2", 4'b0100, 8'hA2);
    tick();
    chk("hol_idle", 64'(bus.out_valid), 64'h0);

    // Filler beat to bring the pointer back to 0
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3F;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("fill", 4'b1000, 8'h3F);
    tick();

    // Addressed mode leaves the round-robin pointer alone
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd3;
    bus.in_data  = 8'h55;
    tick();
    bus.in_sel  = 2'd3;
    bus.in_data = 8'h66;
    #1;
    chk_out("addr_55", 4'b1000, 8'h55);
    tick();
    bus.in_sel  = 2'd0;
    bus.in_data = 8'h77;
    #1;
    chk_out("addr_66", 4'b1000, 8'h66);
    tick();
    bus.mode    = 1'b0;
    bus.in_sel  = 2'd2;
    bus.in_data = 8'h88;
    #1;
    chk_out("addr_77", 4'b0001, 8'h77);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("addr_rr_next", 4'b0001, 8'h88);
    tick();

    // Mode change while a beat for channel 2 is held
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h90;
    bus.out_ready = 4'b1011;
    tick();
    bus.in_data = 8'h91;
    #1;
    chk_out("mode_90", 4'b0010, 8'h90);
    tick();
    bus.in_valid = 1'b0;
    bus.mode     = 1'b1;
    bus.in_sel   = 2'd0;
    #1;
    chk_out("mode_held", 4'b0100, 8'h91);
    chk("mode_held_ready", 64'(bus.in_ready), 64'h0);
    tick();
    chk_out("mode_held2", 4'b0100, 8'h91);
    chk("mode_held_busy", 64'(bus.busy), 64'h1);
    bus.out_ready = 4'hF;
    tick();
    chk("mode_done_valid", 64'(bus.out_valid), 64'h0);
    chk("mode_done_busy", 64'(bus.busy), 64'h0);
`ifdef DEMUX_CNT_EN
    chk("cnt_totals", 64'(bus.out_cnt), 64'h0005_0004_0004_0005);
`endif

    // Reset while holding a beat for channel 1
    bus.mode      = 1'b1;
    bus.in_sel    = 2'd1;
    bus.in_data   = 8'hB1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b1101;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("hold_b1", 4'b0010, 8'hB1);
    rst = 1'b1;
    #1;
    chk("rst_hold_ready", 64'(bus.in_ready), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk_out("rst_hold_out", 4'b0000, 8'h00);
    chk("rst_hold_busy", 64'(bus.busy), 64'h0);
    chk("rst_hold_ready1", 64'(bus.in_ready), 64'h1);
`ifdef DEMUX_CNT_EN
    chk("rst_hold_cnt", 64'(bus.out_cnt), 64'h0);
`endif
    bus.mode      = 1'b0;
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC0;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk_out("rst_rr_ptr0", 4'b0001, 8'hC0);
    tick();

`ifdef DEMUX_CNT_EN
    // Counter wrap: 65537 deliveries to channel 0
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.mode      = 1'b1;
    bus.in_sel    = 2'd0;
    bus.in_data   = 8'h5A;
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("cnt_wrap", 64'(bus.out_cnt), 64'h0000_0000_0000_0001);
    chk("cnt_wrap_idle", 64'(bus.out_valid), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
